// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// imem_responder: Stall/Done memory responder with a fixed-latency word array
//                 and a one-entry last-read buffer for single-cycle repeat reads.
// Revision: 1.0
// ============================================================================
module imem_responder #(
  parameter int AW      = 15,
  parameter int LATENCY = 4,
  parameter bit HIT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:1] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        bad_q, bad_d;
  logic        hit_q, hit_d;
  logic        buf_valid_q, buf_valid_d;
  logic [15:1] buf_tag_q, buf_tag_d;
  logic [15:0] buf_data_q, buf_data_d;
  logic [15:0] dout_q, dout_d;
  logic        done_q, stall_q, cachehit_q, err_q;

  logic [15:0] mem [2**AW];
  logic [15:0] rdata;
  logic        mem_we;
  logic        range_bad;
  logic        illegal;
  logic        lookup_hit;
  logic        unused_dump;

  // The dump is a simulation-environment feature; the input is only sunk here.
  assign unused_dump = createdump;

  generate
    if (AW < 15) begin : g_range_chk
      assign range_bad = |Addr[15:AW+1];
    end else begin : g_range_full
      assign range_bad = 1'b0;
    end
  endgenerate

  assign illegal    = (Rd & Wr) | Addr[0] | range_bad;
  assign lookup_hit = HIT_EN && buf_valid_q && (buf_tag_q == Addr[15:1]);
  assign rdata      = mem[addr_q[AW:1]];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    bad_d       = bad_q;
    hit_d       = hit_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    dout_d      = dout_q;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (Rd | Wr) begin
          addr_d  = Addr[15:1];
          wdata_d = DataIn;
          wr_d    = Wr;
          bad_d   = illegal;
          hit_d   = Rd && !illegal && lookup_hit;
          if (illegal) begin
            state_d = RESP;
            dout_d  = 16'h0000;
          end else if (Rd && lookup_hit) begin
            state_d = RESP;
            dout_d  = buf_data_q;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (!wr_q) begin
            dout_d      = rdata;
            buf_valid_d = 1'b1;
            buf_tag_d   = addr_q;
            buf_data_d  = rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (wr_q && !bad_q) begin
          mem_we = 1'b1;
          if (buf_valid_q && (buf_tag_q == addr_q)) begin
            buf_data_d = wdata_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they stay registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 16'h0000;
      wr_q        <= 1'b0;
      bad_q       <= 1'b0;
      hit_q       <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= 16'h0000;
      dout_q      <= 16'h0000;
      done_q      <= 1'b0;
      stall_q     <= 1'b0;
      cachehit_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      bad_q       <= bad_d;
      hit_q       <= hit_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      dout_q      <= dout_d;
      done_q      <= (state_d == RESP);
      stall_q     <= (state_d == BUSY);
      cachehit_q  <= (state_d == RESP) && hit_d;
      err_q       <= (state_d == RESP) && bad_d;
    end
  end

  // mem_we is only high in RESP, which reset leaves immediately.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q[AW:1]] <= wdata_q;
    end
  end

  assign DataOut  = dout_q;
  assign Done     = done_q;
  assign Stall    = stall_q;
  assign CacheHit = cachehit_q;
  assign err      = err_q;

endmodule
`default_nettype wire
